// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: request side (valid/ready, opcode,
// operands) and response side (valid/ready, result, zero, busy).
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_sel, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, alu_sel, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops, shifts performed one bit
// per cycle under a down-counter, result held until the consumer accepts it.
//
// state | meaning
// IDLE  | ready for a request
// SHIFT | shifting result_q one bit per cycle, cnt_q bits remaining
// DONE  | result valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_SLL = 4'b0010,
                         OP_SLT = 4'b0011, OP_SLTU = 4'b0100, OP_XOR = 4'b0101,
                         OP_SRL = 4'b0110, OP_SRA = 4'b0111, OP_OR = 4'b1000,
                         OP_AND = 4'b1001;

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] alu_d;
  logic [SHW-1:0]   shamt;
  logic             is_shift;

  assign shamt    = bus.b[SHW-1:0];
  assign is_shift = (bus.alu_sel == OP_SLL) || (bus.alu_sel == OP_SRL) ||
                    (bus.alu_sel == OP_SRA);

  // Shift opcodes pass a through; the shifting itself happens in SHIFT.
  always_comb begin
    alu_d = '0;
    case (bus.alu_sel)
      OP_ADD:  alu_d = bus.a + bus.b;
      OP_SUB:  alu_d = bus.a - bus.b;
      OP_SLT:  alu_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_XOR:  alu_d = bus.a ^ bus.b;
      OP_OR:   alu_d = bus.a | bus.b;
      OP_AND:  alu_d = bus.a & bus.b;
      OP_SLL, OP_SRL, OP_SRA: alu_d = bus.a;
      default: alu_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            op_q       <= bus.alu_sel;
            if (is_shift && (shamt != '0)) begin
              state_q  <= SHIFT;
              result_q <= bus.a;
              cnt_q    <= shamt;
            end else begin
              state_q     <= DONE;
              result_q    <= alu_d;
              out_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          case (op_q)
            OP_SLL:  result_q <= result_q << 1;
            OP_SRL:  result_q <= result_q >> 1;
            default: result_q <= WIDTH'($signed(result_q) >>> 1);
          endcase
          cnt_q <= cnt_q - 1'b1;
          // Last shift lands in the same edge that moves to DONE.
          if (cnt_q == SHW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, hand-written reset
// sequences, and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          bp;
  } vec_t;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] sel,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [4:0]  sh;
    sh = b[4:0];
    case (sel)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a << sh;
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = (a < b) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: r = a >> sh;
      4'd7: r = $signed(a) >>> sh;
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [3:0] sel, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    if ((sel == 4'd2 || sel == 4'd6 || sel == 4'd7) && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string name);
    chk(bus.in_ready === 1'b1, {name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk(bus.out_valid === 1'b0, {name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk(bus.busy === 1'b0, {name, "_busy"}, 32'(bus.busy), 32'd0);
    chk(bus.result === 32'd0, {name, "_result"}, bus.result, 32'd0);
    chk(bus.zero === 1'b1, {name, "_zero"}, 32'(bus.zero), 32'd1);
  endtask

  // Called at a negedge with the block idle; returns at a negedge.
  task automatic do_op(input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input int bp,
                       input logic [31:0] exp_res, input int exp_lat,
                       input string name);
    int lat;
    bit seen;
    bit bad;
    bus.in_valid  = 1'b1;
    bus.alu_sel   = sel;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Junk on the request side while busy must be ignored.
    bus.a       = $urandom;
    bus.b       = $urandom;
    bus.alu_sel = 4'($urandom_range(0, 15));
    lat = 1;
    seen = 1'b0;
    bad = 1'b0;
    while (lat <= 40) begin
      if (bus.out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      chk(1'b0, {name, "_timeout"}, 32'(lat), 32'(exp_lat));
      pulse_reset();
      return;
    end
    bus.out_ready = 1'b0;
    chk(lat == exp_lat, {name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk(bus.result === exp_res, {name, "_result"}, bus.result, exp_res);
    chk(bus.zero === (exp_res == 32'd0), {name, "_zero"}, 32'(bus.zero),
        32'(exp_res == 32'd0));
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.result !== exp_res || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(bus.out_valid === 1'b0 && bus.in_ready === 1'b1 && bus.busy === 1'b0,
        {name, "_handshake"}, {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'd2);
    chk(!bad, {name, "_hold"}, 32'(bad), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0]  rs;
    logic [31:0] ra, rb;

    vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1,  0});
    vecs.push_back('{4'b0011, 32'hFFFFFFFF, 32'h0,        32'h1,        1,  0});
    vecs.push_back('{4'b0100, 32'hFFFFFFFF, 32'h0,        32'h0,        1,  0});
    vecs.push_back('{4'b0111, 32'h80000000, 32'h00000024, 32'hF8000000, 5,  0});
    vecs.push_back('{4'b0010, 32'h1,        32'h0,        32'h1,        1,  0});
    vecs.push_back('{4'b0010, 32'h1,        32'd31,       32'h80000000, 32, 0});
    vecs.push_back('{4'b0101, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 1,  3});
    vecs.push_back('{4'b1010, 32'h5,        32'h7,        32'h0,        1,  0});
    vecs.push_back('{4'b1111, 32'hFFFFFFFF, 32'h1,        32'h0,        1,  1});
    vecs.push_back('{4'b0001, 32'h0,        32'h1,        32'hFFFFFFFF, 1,  0});
    vecs.push_back('{4'b0110, 32'h80000000, 32'hFFFFFFE3, 32'h10000000, 4,  2});
    vecs.push_back('{4'b1001, 32'hF0F0F0F0, 32'h3C3C3C3C, 32'h30303030, 1,  0});
    vecs.push_back('{4'b1000, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1,  0});
    vecs.push_back('{4'b0010, 32'h1,        32'h00000020, 32'h1,        1,  0});
    vecs.push_back('{4'b0111, 32'h40000000, 32'd3,        32'h08000000, 4,  0});

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_sel   = 4'd0;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bp, vecs[i].res,
            vecs[i].lat, $sformatf("vec%0d", i));

    // Reset in the second SHIFT cycle of SRL shamt=10.
    bus.in_valid = 1'b1;
    bus.alu_sel  = 4'b0110;
    bus.a        = 32'hFFFF0000;
    bus.b        = 32'd10;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b0;
    check_idle("rst_shift");
    begin
      bit pulse = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.out_valid !== 1'b0) pulse = 1'b1;
      end
      chk(!pulse, "rst_shift_no_valid", 32'(pulse), 32'd0);
    end
    do_op(4'b0000, 32'd2, 32'd3, 0, 32'd5, 1, "add_after_rst");

    // Reset while holding a result in DONE, with in_valid also high.
    bus.in_valid = 1'b1;
    bus.alu_sel  = 4'b0000;
    bus.a        = 32'd7;
    bus.b        = 32'd9;
    @(posedge clk);
    @(negedge clk);
    chk(bus.out_valid === 1'b1 && bus.result === 32'd16, "done_before_rst",
        bus.result, 32'd16);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("rst_done");

    // Reset wins over a simultaneous request in IDLE.
    bus.in_valid = 1'b1;
    bus.alu_sel  = 4'b0001;
    bus.a        = 32'd1;
    bus.b        = 32'd5;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check_idle("rst_prio");

    for (int k = 0; k < 200; k++) begin
      rs = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 0) ra = {ra[31], 31'd0} | (ra & 32'h000000FF);
      do_op(rs, ra, rb, $urandom_range(0, 2), model(rs, ra, rb),
            model_lat(rs, rb), $sformatf("rnd%0d_op%0d", k, rs));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operation request present.
REQ-007 in_ready  output  1  block can accept a request.
REQ-008 alu_sel  input  4  ALU operation code, as produced by the ALU control decoder.
REQ-009 a  input  WIDTH  operand A (rs1).
REQ-010 b  input  WIDTH  operand B (rs2 or immediate); b[SHW-1:0] is the shift amount.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  operation result.
REQ-014 zero  output  1  high when result == 0.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 alu_sel encoding SHALL be ADD=0000, SUB=0001, SLL=0010, SLT=0011, SLTU=0100, XOR=0101, SRL=0110, SRA=0111, OR=1000, AND=1001.
REQ-017 Codes 1010-1111 SHALL produce result=0 with single-cycle latency and no error flag.
REQ-018 FSM states SHALL be IDLE, SHIFT and DONE; reset state is IDLE.
REQ-019 in_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where in_valid && in_ready.
REQ-020 a, b and alu_sel SHALL be captured at acceptance; later input changes SHALL have no effect on the operation in flight.
REQ-021 Non-shift operations SHALL go IDLE->DONE with result registered; out_valid is asserted in the cycle after acceptance.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT compares signed, SLTU unsigned, and each returns 1 or 0 zero-extended.
REQ-023 Shift operations with shamt != 0 SHALL go IDLE->SHIFT and shift one bit per cycle, with a shamt down-counter.
REQ-024 In SHIFT, SLL inserts 0 at the LSB, SRL inserts 0 at the MSB, and SRA replicates the captured MSB.
REQ-025 SHIFT->DONE SHALL occur on the cycle the counter reaches 0; out_valid is asserted shamt+1 cycles after acceptance.
REQ-026 A shift with shamt==0 SHALL go IDLE->DONE with result=a, latency 1.
REQ-027 Only b[SHW-1:0] SHALL be used as the shift amount; upper b bits are ignored.
REQ-028 In DONE, out_valid=1 and result/zero SHALL hold stable until out_ready=1.
REQ-029 On a DONE handshake the block SHALL return to IDLE; in_ready rises the next cycle, with no same-cycle accept.
REQ-030 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-031 zero SHALL be derived from the registered result and is meaningful whenever out_valid=1.

Reset
REQ-032 rst SHALL force state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero=1 and shift counter=0 on the next edge.
REQ-033 rst asserted during SHIFT or DONE SHALL abort the operation and produce no out_valid pulse.
REQ-034 rst SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-035 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0, zero=1.
REQ-036 SLT a=0xFFFFFFFF, b=0 -> result=1; SLTU with the same operands -> result=0.
REQ-037 SRA a=0x80000000, b=0x00000024 (shamt=4) -> out_valid 5 cycles after accept, result=0xF8000000; busy=1 for 4 SHIFT cycles plus DONE.
REQ-038 SLL a=0x1, b=0 -> result=0x1 with latency 1; SLL b=31 -> result=0x80000000 with latency 32.
REQ-039 Backpressure: XOR a=0xF0F0F0F0, b=0xFFFFFFFF with out_ready=0 for 3 cycles -> result=0x0F0F0F0F held; in_ready=0 until the cycle after out_ready=1.
REQ-040 rst asserted in the 2nd SHIFT cycle of SRL shamt=10 -> next cycle IDLE, out_valid=0, result=0; a following ADD 2+3 returns 5.
